// File: rtl/if_fetch_stage.sv
// rtl/if_fetch_stage.sv - RV32I instruction fetch stage with PC, single-outstanding imem port and IF/DEC slot
module if_fetch_stage #(
    parameter logic [31:0] RESET_VEC = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        LW_STALL,
    input  logic        IF_FLUSH,
    input  logic        DEC_FLUSH,
    input  logic [2:0]  pc_source,
    input  logic [31:0] jalr_addr,
    input  logic [31:0] branch_addr,
    input  logic [31:0] jal_addr,
    input  logic [31:0] mtvec,
    input  logic [31:0] mepc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_valid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] dec_ir,
    output logic [31:0] dec_pc,
    output logic        dec_valid,
    output logic        if_busy
);

    localparam logic [1:0] ST_ISSUE = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    logic [1:0]  state_q;
    logic [31:0] pc_q;
    logic [31:0] req_pc_q;
    logic        kill_q;
    logic [31:0] buf_ir;
    logic [31:0] buf_pc;
    logic        redirect;
    logic [31:0] raw_target;
    logic [31:0] target;

    assign redirect = IF_FLUSH | DEC_FLUSH;

    always_comb begin
        raw_target = pc_q + 32'd4;
        case (pc_source)
            3'd1:    raw_target = jalr_addr;
            3'd2:    raw_target = branch_addr;
            3'd3:    raw_target = jal_addr;
            3'd4:    raw_target = mtvec;
            3'd5:    raw_target = mepc;
            default: raw_target = pc_q + 32'd4;
        endcase
        target = raw_target & ~32'd3;
    end

    // Request is gated by reset combinationally so nothing is issued while held in reset.
    assign imem_req  = RST_N && (state_q == ST_ISSUE);
    assign imem_addr = pc_q;
    assign if_busy   = (state_q != ST_ISSUE);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= ST_ISSUE;
            pc_q      <= RESET_VEC;
            req_pc_q  <= 32'h0;
            kill_q    <= 1'b0;
            buf_ir    <= 32'h0;
            buf_pc    <= 32'h0;
            dec_ir    <= 32'h0;
            dec_pc    <= 32'h0;
            dec_valid <= 1'b0;
        end else if (redirect) begin
            pc_q      <= target;
            dec_ir    <= 32'h0;
            dec_valid <= 1'b0;
            buf_ir    <= 32'h0;
            buf_pc    <= 32'h0;
            case (state_q)
                ST_ISSUE: begin
                    // An accepted request still completes; its response is marked stale.
                    if (imem_ready) begin
                        req_pc_q <= pc_q;
                        kill_q   <= 1'b1;
                        state_q  <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (imem_valid) begin
                        kill_q  <= 1'b0;
                        state_q <= ST_ISSUE;
                    end else begin
                        kill_q  <= 1'b1;
                    end
                end
                default: state_q <= ST_ISSUE;
            endcase
        end else begin
            if (!LW_STALL) begin
                dec_ir    <= 32'h0;
                dec_valid <= 1'b0;
            end
            case (state_q)
                ST_ISSUE: begin
                    if (imem_ready) begin
                        req_pc_q <= pc_q;
                        pc_q     <= pc_q + 32'd4;
                        state_q  <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (imem_valid) begin
                        if (kill_q) begin
                            kill_q  <= 1'b0;
                            state_q <= ST_ISSUE;
                        end else if (!LW_STALL) begin
                            dec_ir    <= imem_rdata;
                            dec_pc    <= req_pc_q;
                            dec_valid <= 1'b1;
                            state_q   <= ST_ISSUE;
                        end else begin
                            buf_ir  <= imem_rdata;
                            buf_pc  <= req_pc_q;
                            state_q <= ST_FULL;
                        end
                    end
                end
                ST_FULL: begin
                    if (!LW_STALL) begin
                        dec_ir    <= buf_ir;
                        dec_pc    <= buf_pc;
                        dec_valid <= 1'b1;
                        state_q   <= ST_ISSUE;
                    end
                end
                default: state_q <= ST_ISSUE;
            endcase
        end
    end

endmodule
